// File: rtl/dct_1d_param.sv
// 8-point 1-D DCT / IDCT over a row-major sample stream: buffer a row, copy it to a
// hold register, then emit one rounded, saturated coefficient per cycle.

module dct_lane #(
  parameter int IN_W = 8,
  parameter int FRAC = 12,
  parameter int LANE = 0,
  parameter int CW   = FRAC + 1
) (
  input  logic                     clk,
  input  logic signed [IN_W-1:0]   a,
  input  logic [2:0]               k,
  input  logic                     inv,
  output logic signed [IN_W+CW-1:0] prod
);

  localparam real PI = 3.14159265358979323846;

  // cos(m*pi/16) by a Taylor series on the angle folded into [0, pi]
  function automatic real cos_pi16(input int m);
    real x, term, s;
    int  r;
    r = m % 32;
    if (r > 16) r = 32 - r;
    x    = real'(r) * PI / 16.0;
    term = 1.0;
    s    = 1.0;
    for (int i = 1; i <= 30; i++) begin
      term = -term * x * x / real'((2*i - 1) * (2*i));
      s    = s + term;
    end
    return s;
  endfunction

  // Q[kk][nn], rounded half away from zero
  function automatic int qcoef(input int kk, input int nn);
    real v, sc;
    sc = 1.0;
    for (int i = 0; i < FRAC; i++) sc = sc * 2.0;
    v = cos_pi16((2*nn + 1) * kk) * sc / 2.0;
    if (kk == 0) v = v * 0.70710678118654752440;
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Column of coefficients this lane needs, indexed by output k
  function automatic logic [7:0][CW-1:0] coef_col(input bit tr);
    logic [7:0][CW-1:0] col;
    for (int j = 0; j < 8; j++)
      col[j] = CW'(tr ? qcoef(LANE, j) : qcoef(j, LANE));
    return col;
  endfunction

  localparam logic [7:0][CW-1:0] COLF = coef_col(1'b0);
  localparam logic [7:0][CW-1:0] COLI = coef_col(1'b1);

  logic signed [CW-1:0] coef;

  assign coef = inv ? $signed(COLI[k]) : $signed(COLF[k]);

  always_ff @(posedge clk)
    prod <= a * coef;

endmodule

module dct_1d_param #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12,
  parameter int FRAC  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena_in,
  input  logic signed [IN_W-1:0]  a_in,
  input  logic                    inv_in,
  output logic signed [OUT_W-1:0] S_out,
  output logic                    ena_out,
  output logic [2:0]              idx_out,
  output logic                    sat_out
);

  localparam int NUM_LANES = 8;
  localparam int CW        = FRAC + 1;
  localparam int PW        = IN_W + CW;
  localparam int ACC_W     = IN_W + FRAC + 5;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SMAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic {IDLE, RUN} state_t;

  logic [2:0]                            cnt;
  logic [NUM_LANES-2:0][IN_W-1:0]        sbuf;
  logic                                  row_inv;
  logic [NUM_LANES-1:0][IN_W-1:0]        hold;
  logic                                  hold_inv;
  logic                                  ld;
  state_t                                st, st_n;
  logic [2:0]                            k_q, k_n;
  logic [NUM_LANES-1:0][PW-1:0]          prod;
  logic [1:0]                            vld_pipe;
  logic [2:0]                            idx_p;
  logic signed [ACC_W-1:0]               acc, biased, rnd;
  logic signed [OUT_W-1:0]               s_n;
  logic                                  sat_n;

  assign ld = ena_in && (cnt == 3'd7);

  // Row capture: sample 7 goes straight to the hold register with the buffered 0..6
  always_ff @(posedge clk) begin
    if (ena_in) begin
      for (int i = 0; i < NUM_LANES - 1; i++)
        if (cnt == 3'(i)) sbuf[i] <= a_in;
      if (cnt == 3'd0) row_inv <= inv_in;
    end
    if (ld) begin
      hold     <= {a_in, sbuf};
      hold_inv <= row_inv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      st       <= IDLE;
      k_q      <= '0;
      vld_pipe <= '0;
      idx_p    <= '0;
    end else begin
      if (ena_in) cnt <= cnt + 3'd1;
      st       <= st_n;
      k_q      <= k_n;
      vld_pipe <= {vld_pipe[0], st == RUN};
      idx_p    <= k_q;
    end
  end

  // A new hold load always restarts the burst at k=0
  always_comb begin
    st_n = st;
    k_n  = k_q;
    if (ld) begin
      st_n = RUN;
      k_n  = '0;
    end else if (st == RUN) begin
      k_n = k_q + 3'd1;
      if (k_q == 3'd7) st_n = IDLE;
    end
  end

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    dct_lane #(.IN_W(IN_W), .FRAC(FRAC), .LANE(n), .CW(CW)) u_lane (
      .clk  (clk),
      .a    (hold[n]),
      .k    (k_q),
      .inv  (hold_inv),
      .prod (prod[n])
    );
  end

  always_comb begin
    acc = '0;
    for (int n = 0; n < NUM_LANES; n++)
      acc = acc + ACC_W'($signed(prod[n]));
    biased = acc + HALF;
    rnd    = biased >>> FRAC;
    sat_n  = 1'b0;
    s_n    = rnd[OUT_W-1:0];
    if (rnd > SMAX) begin
      s_n   = SMAX[OUT_W-1:0];
      sat_n = 1'b1;
    end else if (rnd < SMIN) begin
      s_n   = SMIN[OUT_W-1:0];
      sat_n = 1'b1;
    end
  end

  // Outputs are forced to zero whenever no valid result is presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_out   <= '0;
      idx_out <= '0;
      sat_out <= 1'b0;
    end else if (vld_pipe[0]) begin
      S_out   <= s_n;
      idx_out <= idx_p;
      sat_out <= sat_n;
    end else begin
      S_out   <= '0;
      idx_out <= '0;
      sat_out <= 1'b0;
    end
  end

  assign ena_out = vld_pipe[1];

endmodule
